os_psum_drain: RTL and testbench
================================

# os_psum_drain

Output-stationary drain controller and collector for the south edge of the MAC array. On a start pulse it drives the tile-array drain protocol: one cycle of `recall_psum`, then `pass_psum` cycles that shift accumulated psums south. It captures one row vector from the bottom-row `out_s` bus per pass cycle and presents it downstream with a valid/ready handshake. It sits between the MAC array's south edge and the output FIFO/SFU, and generates the two drain control lines broadcast to every tile.

## Interface
- `row`, default 8: number of tile rows, which is also the number of pass cycles per drain.
- `col`, default 8: number of tile columns.
- `psum_bw`, default 16: psum width per column, signed two's complement.

Clock is `clk`; reset is `reset`, synchronous and active-high.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `weight_stationary` in 1: array mode; a start is ignored while it is 1.
- `start` in 1: single-cycle request to drain; sampled only in IDLE.
- `recall_psum` out 1: broadcast to all tiles.
- `pass_psum` out 1: broadcast to all tiles.
- `array_out_s` in col*psum_bw: bottom-row `out_s` bus; column c occupies bits [c*psum_bw +: psum_bw].
- `out_data` out col*psum_bw: captured row vector.
- `out_row_idx` out $clog2(row): array row index of `out_data`.
- `out_valid` out 1: `out_data` holds an unconsumed vector.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: single-cycle pulse when the last row is accepted.

## Operation
- States and transitions:
  - IDLE → RECALL on `start && !weight_stationary`.
  - RECALL → PASS after exactly 1 cycle.
  - PASS → FLUSH after `row` captures.
  - FLUSH → IDLE when the final vector is accepted.
- `recall_psum` is 1 only in RECALL.
- `pass_psum` = (state==PASS) && (!out_valid || out_ready). Backpressure therefore freezes the shift: tiles hold `c_q` while `pass_psum` is 0.
- Capture: on every edge where `pass_psum`=1:
  - `out_data` <= `array_out_s`.
  - `out_valid` <= 1.
  - `out_row_idx` <= row-1-k, where k is the capture count 0..row-1. The bottom row emerges first.
  - k is incremented.
- Acceptance: `out_valid && out_ready` with no simultaneous capture clears `out_valid`. A simultaneous capture and accept leaves `out_valid`=1 and loads the new data.
- `done` pulses in the cycle after the accepting edge of the row-0 vector, coincident with the return to IDLE.
- `start` is ignored outside IDLE. A start with `weight_stationary`=1 leaves the block in IDLE, with no outputs changed.
- Width rule: data passes through unmodified, with no sign extension. Columns are independent.

## Timing
- Reset values: state IDLE, k=0, `recall_psum`=0, `pass_psum`=0, `out_valid`=0, `out_data`=0, `out_row_idx`=0, `busy`=0, `done`=0.
- Reset mid-drain returns to IDLE on the next edge and discards any unaccepted vector. Array contents are not restored.
- Latency with `out_ready` held at 1:
  - start edge T.
  - RECALL in cycle T+1.
  - PASS in cycles T+2..T+row+1.
  - First `out_valid` in cycle T+3.
  - Last vector in cycle T+row+2.
  - `done` in cycle T+row+3.
  - Total: row+3 cycles from start to done.
- With `out_ready` stalled, `pass_psum` stays 0. No vector is lost or duplicated, and k does not advance.
- Outputs are registered except `pass_psum`, which is combinational from state, `out_valid` and `out_ready`.

## Configuration
- `OS_DRAIN_RELU_EN`:
  - When defined, each captured column value with its MSB set is replaced by 0 before being registered into `out_data`.
  - When undefined, values pass unchanged.
  - No port or timing difference in either case.

## Structure
- Shared package `os_drain_pkg` holds:
  - The state encoding typedef (IDLE, RECALL, PASS, FLUSH).
  - A default-geometry constant.
  - The `$clog2(row)` width helper.
- One sub-module, `psum_capture_reg`: the valid/ready single-entry output register with optional ReLU, instantiated once over the full col*psum_bw vector.
- The FSM and row counter live in `os_psum_drain`.

## Test plan
- Test geometry is row=4, col=4. A bench model of the array shifts preloaded psums south on `pass_psum`.
- Basic drain: preload rows 0..3 = 0x0010·(r+1) in every column; pulse `start` with `out_ready`=1 → `recall_psum` is high for 1 cycle, `pass_psum` is high for 4 cycles, vectors arrive in `out_row_idx` order 3,2,1,0 carrying 0x0040, 0x0030, 0x0020, 0x0010, and `done` pulses 7 cycles after start.
- Backpressure: hold `out_ready`=0 for 5 cycles after the first valid → `out_data` stays 0x0040, `pass_psum` stays 0, and the remaining rows arrive intact after release.
- Mode guard: `start` with `weight_stationary`=1 → `busy` stays 0 and `recall_psum`/`pass_psum` are never asserted.
- Reset mid-drain: assert `reset` after 2 captures → next cycle IDLE, `out_valid`=0, `pass_psum`=0; a subsequent start drains normally.
- ReLU: a column value of 0xFFF0 yields 0x0000 with `OS_DRAIN_RELU_EN` defined and 0xFFF0 without it; a value of 0x7FFF is unchanged in both builds.

Source files
------------

// File: rtl/os_drain_pkg.sv
// Shared definitions for the output-stationary psum drain: state encoding,
// default array geometry and the index-width helper.
package os_drain_pkg;

    localparam int unsigned DEFAULT_GEOM = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECALL = 2'd1,
        PASS   = 2'd2,
        FLUSH  = 2'd3
    } drain_state_e;

    // $clog2 that never collapses to a zero-width vector
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_capture_reg.sv
// Single-entry valid/ready output register for one drained row vector.
// Define OS_DRAIN_RELU_EN to clamp negative column values to zero on capture.
module psum_capture_reg #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned idx_bw  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     ready,
    input  logic [col*psum_bw-1:0]   din,
    input  logic [idx_bw-1:0]        din_idx,
    output logic [col*psum_bw-1:0]   data,
    output logic [idx_bw-1:0]        idx,
    output logic                     valid
);

    localparam int unsigned VEC_W = col * psum_bw;

    logic [VEC_W-1:0] filtered;

    // Per-column filter applied before the data is registered
    always_comb begin
        filtered = din;
`ifdef OS_DRAIN_RELU_EN
        for (int unsigned c = 0; c < col; c++) begin
            if (din[c*psum_bw + psum_bw - 1]) begin
                filtered[c*psum_bw +: psum_bw] = '0;
            end
        end
`endif
    end

    // A load wins over an accept so a same-edge capture keeps valid high
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= filtered;
            idx   <= din_idx;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/os_psum_drain.sv
// Drain controller for the MAC array south edge: sequences recall/pass,
// captures one row per pass cycle and hands it downstream. ReLU via OS_DRAIN_RELU_EN.
module os_psum_drain
    import os_drain_pkg::*;
#(
    parameter int unsigned row     = DEFAULT_GEOM,
    parameter int unsigned col     = DEFAULT_GEOM,
    parameter int unsigned psum_bw = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          weight_stationary,
    input  logic                          start,
    output logic                          recall_psum,
    output logic                          pass_psum,
    input  logic [col*psum_bw-1:0]        array_out_s,
    output logic [col*psum_bw-1:0]        out_data,
    output logic [idx_width(row)-1:0]     out_row_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned IDX_W = idx_width(row);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(row - 1);

    drain_state_e      state;
    drain_state_e      next_state;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  cap_idx;

    // Shift only when the output slot is free or being emptied this edge
    assign pass_psum = (state == PASS) && (!out_valid || out_ready);
    assign cap_idx   = LAST - k;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !weight_stationary) next_state = RECALL;
            RECALL:  next_state = PASS;
            PASS:    if (pass_psum && (k == LAST)) next_state = FLUSH;
            FLUSH:   if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            recall_psum <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= next_state;
            recall_psum <= (next_state == RECALL);
            busy        <= (next_state != IDLE);
            done        <= (state == FLUSH) && out_valid && out_ready;
            if (state != PASS) begin
                k <= '0;
            end else if (pass_psum) begin
                k <= k + IDX_W'(1);
            end
        end
    end

    psum_capture_reg #(
        .col     (col),
        .psum_bw (psum_bw),
        .idx_bw  (IDX_W)
    ) u_capture (
        .clk     (clk),
        .reset   (reset),
        .load    (pass_psum),
        .ready   (out_ready),
        .din     (array_out_s),
        .din_idx (cap_idx),
        .data    (out_data),
        .idx     (out_row_idx),
        .valid   (out_valid)
    );

endmodule

// File: tb/tb_os_psum_drain.sv
// Bench for os_psum_drain at row=4, col=4: an array model shifts preloaded
// psums south on pass_psum and accepted vectors are scored against the preload.
module tb_os_psum_drain;

    localparam int unsigned ROW = 4;
    localparam int unsigned COL = 4;
    localparam int unsigned BW  = 16;
    localparam int unsigned IW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 weight_stationary;
    logic                 start;
    logic                 recall_psum;
    logic                 pass_psum;
    logic [COL*BW-1:0]    array_out_s;
    logic [COL*BW-1:0]    out_data;
    logic [IW-1:0]        out_row_idx;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;

    int vectors = 0;
    int errors  = 0;

    logic [BW-1:0] mat [ROW][COL];
    logic [BW-1:0] arr [ROW][COL];

    logic [COL*BW-1:0] got_data [$];
    int                got_idx  [$];
    int n_recall, n_pass, done_cyc, n_viol, n_change, timed_out;

    always #5 clk = ~clk;

    os_psum_drain #(.row(ROW), .col(COL), .psum_bw(BW)) dut (
        .clk               (clk),
        .reset             (reset),
        .weight_stationary (weight_stationary),
        .start             (start),
        .recall_psum       (recall_psum),
        .pass_psum         (pass_psum),
        .array_out_s       (array_out_s),
        .out_data          (out_data),
        .out_row_idx       (out_row_idx),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .busy              (busy),
        .done              (done)
    );

    // Array model: bottom row drives out_s, everything moves one row south per pass
    always_comb begin
        array_out_s = '0;
        for (int c = 0; c < COL; c++) array_out_s[c*BW +: BW] = arr[ROW-1][c];
    end

    always @(posedge clk) begin
        if (pass_psum) begin
            for (int r = ROW - 1; r > 0; r--)
                for (int c = 0; c < COL; c++) arr[r][c] <= arr[r-1][c];
            for (int c = 0; c < COL; c++) arr[0][c] <= '0;
        end
    end

    function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef OS_DRAIN_RELU_EN
        return v[BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [COL*BW-1:0] expect_vec(input int r);
        logic [COL*BW-1:0] v;
        v = '0;
        for (int c = 0; c < COL; c++) v[c*BW +: BW] = relu(mat[r][c]);
        return v;
    endfunction

    task automatic preload();
        @(negedge clk);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) arr[r][c] <= mat[r][c];
    endtask

    // Pulse start and collect everything until done; mode 0 ready=1,
    // mode 1 ready=0 for 5 cycles from first valid, mode 2 random ready
    task automatic run_drain(input int mode, input int budget);
        logic rec, val, dn, ps, rdy, first_seen, prev_stall;
        logic [COL*BW-1:0] dat, prev_dat;
        int idx, stall_left, finished;
        got_data.delete();
        got_idx.delete();
        n_recall = 0; n_pass = 0; done_cyc = -1; n_viol = 0; n_change = 0; timed_out = 0;
        first_seen = 0; prev_stall = 0; prev_dat = '0; stall_left = 5; finished = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge clk);
            rec = recall_psum; val = out_valid; dat = out_data; idx = int'(out_row_idx); dn = done;
            rdy = 1'b1;
            if (mode == 1) begin
                if (val) first_seen = 1'b1;
                if (first_seen && stall_left > 0) begin rdy = 1'b0; stall_left--; end
            end else if (mode == 2) begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            out_ready = rdy;
            #1;
            ps = pass_psum;
            if (rec) n_recall++;
            if (ps) n_pass++;
            if (ps && val && !rdy) n_viol++;
            if (val && prev_stall && dat !== prev_dat) n_change++;
            prev_stall = val && !rdy;
            prev_dat = dat;
            if (val && rdy) begin got_data.push_back(dat); got_idx.push_back(idx); end
            if (dn) begin done_cyc = c; finished = 1; break; end
        end
        if (finished == 0) timed_out = 1;
        @(negedge clk);
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; weight_stationary = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) arr[r][c] <= '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        vectors++; if ({recall_psum, pass_psum, out_valid, busy, done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b want=00000", {recall_psum, pass_psum, out_valid, busy, done});
        end
        vectors++; if (out_data !== '0) begin
            errors++; $display("FAIL reset_data got=%h want=0", out_data);
        end
        vectors++; if (out_row_idx !== '0) begin
            errors++; $display("FAIL reset_idx got=%0d want=0", out_row_idx);
        end
    endtask

    task automatic check_vectors(input string name);
        vectors++; if (timed_out != 0 || got_data.size() != ROW) begin
            errors++; $display("FAIL %s_count got=%0d timeout=%0d want=%0d", name, got_data.size(), timed_out, ROW);
        end
        for (int i = 0; i < ROW && i < got_data.size(); i++) begin
            vectors++; if (got_idx[i] !== ROW - 1 - i || got_data[i] !== expect_vec(ROW - 1 - i)) begin
                errors++; $display("FAIL %s_vec%0d got idx=%0d data=%h want idx=%0d data=%h",
                                   name, i, got_idx[i], got_data[i], ROW - 1 - i, expect_vec(ROW - 1 - i));
            end
        end
        vectors++; if (n_pass != ROW || n_viol != 0 || n_change != 0) begin
            errors++; $display("FAIL %s_pass got pass=%0d viol=%0d change=%0d want %0d/0/0", name, n_pass, n_viol, n_change, ROW);
        end
    endtask

    task automatic test_basic();
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) mat[r][c] = BW'(16 * (r + 1));
        preload();
        run_drain(0, 40);
        check_vectors("basic");
        vectors++; if (n_recall != 1) begin
            errors++; $display("FAIL basic_recall got=%0d want=1", n_recall);
        end
        vectors++; if (done_cyc != ROW + 3) begin
            errors++; $display("FAIL basic_done_latency got=%0d want=%0d", done_cyc, ROW + 3);
        end
        vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle got busy=%b valid=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) mat[r][c] = BW'(16 * (r + 1));
        preload();
        run_drain(1, 60);
        check_vectors("backpressure");
        vectors++; if (done_cyc != ROW + 3 + 5) begin
            errors++; $display("FAIL backpressure_done got=%0d want=%0d", done_cyc, ROW + 8);
        end
    endtask

    task automatic test_mode_guard();
        int bad;
        bad = 0;
        weight_stationary = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (busy || recall_psum || pass_psum || out_valid) bad++;
            @(negedge clk);
        end
        weight_stationary = 1'b0;
        vectors++; if (bad != 0) begin
            errors++; $display("FAIL mode_guard active_cycles got=%0d want=0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) mat[r][c] = BW'($urandom);
        preload();
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            if (out_valid) seen++;
            if (seen < 2) @(negedge clk);
        end
        vectors++; if (seen != 2) begin
            errors++; $display("FAIL reset_mid_captures got=%0d want=2", seen);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || pass_psum !== 1'b0 || busy !== 1'b0 || recall_psum !== 1'b0) begin
            errors++; $display("FAIL reset_mid_idle got valid=%b pass=%b busy=%b recall=%b want 0000",
                               out_valid, pass_psum, busy, recall_psum);
        end
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) mat[r][c] = BW'($urandom);
        preload();
        run_drain(0, 40);
        check_vectors("reset_mid_redrain");
        vectors++; if (done_cyc != ROW + 3) begin
            errors++; $display("FAIL reset_mid_done got=%0d want=%0d", done_cyc, ROW + 3);
        end
    endtask

    task automatic test_relu();
        logic [BW-1:0] neg_want;
        for (int r = 0; r < ROW; r++) begin
            mat[r][0] = 16'hFFF0;
            mat[r][1] = 16'h7FFF;
            mat[r][2] = BW'($urandom);
            mat[r][3] = BW'($urandom);
        end
`ifdef OS_DRAIN_RELU_EN
        neg_want = 16'h0000;
`else
        neg_want = 16'hFFF0;
`endif
        preload();
        run_drain(0, 40);
        check_vectors("relu");
        vectors++; if (got_data.size() < 1 || got_data[0][BW-1:0] !== neg_want || got_data[0][2*BW-1:BW] !== 16'h7FFF) begin
            errors++; $display("FAIL relu_cols got=%h want col0=%h col1=7fff",
                               (got_data.size() > 0) ? got_data[0] : '0, neg_want);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) mat[r][c] = BW'($urandom);
            preload();
            run_drain(2, 120);
            check_vectors("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_mode_guard();
        test_reset_mid();
        test_relu();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
